// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, common command
// bytes and the frame parity helper. Used by the transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    START   = 3'd2,
    SEND    = 3'd3,
    ACK     = 3'd4
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ACK     = 8'hFA;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a falling-edge
// detector on the synchronized clock. Shared by the host transmitter and receiver.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_old;

  // Synchronize both lines and keep one cycle of history on the clock line;
  // reset to 1 so an idle (pulled-up) bus produces no spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_ff  <= 2'b11;
      data_ff <= 2'b11;
      clk_old <= 1'b1;
    end else begin
      clk_ff  <= {clk_ff[0], ps2_clk};
      data_ff <= {data_ff[0], ps2_data};
      clk_old <= clk_ff[1];
    end
  end

  assign data_sync = data_ff[1];
  assign clk_fall  = clk_old & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, issues the
// request-to-send, shifts out data/parity/stop on device clock falls and
// checks the device ACK. Defining PS2_TX_TIMEOUT_EN adds a watchdog that
// aborts a frame TIMEOUT_CYCLES clocks after START.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       key_clk_drv,
  output logic       key_data_drv,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  ps2_state_e    state, state_next;
  logic [IW-1:0] inh_cnt, inh_cnt_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    frame_byte;
  logic          frame_parity;
  logic          clk_drv_next, data_drv_next;
  logic          done_next, err_next, ready_next;
  logic          data_sync, clk_fall;
  logic          accept;
  logic          wd_expired;

  ps2_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (key_clk),
    .ps2_data  (key_data),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  assign accept = (state == IDLE) && tx_valid && tx_ready;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wd_cnt;
  logic          wd_active;

  assign wd_active  = (state == START) || (state == SEND) || (state == ACK);
  assign wd_expired = wd_active && (wd_cnt == WD_LAST);

  // Watchdog: counts every cycle from START until the frame leaves ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (wd_active && (state_next != IDLE)) begin
      wd_cnt <= wd_cnt + WW'(1);
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Latch the accepted byte and its parity so later tx_data changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_byte   <= 8'h00;
      frame_parity <= 1'b0;
    end else if (accept) begin
      frame_byte   <= tx_data;
      frame_parity <= odd_parity(tx_data);
    end else begin
      frame_byte   <= frame_byte;
      frame_parity <= frame_parity;
    end
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_next    = state;
    inh_cnt_next  = inh_cnt;
    bit_cnt_next  = bit_cnt;
    clk_drv_next  = 1'b0;
    data_drv_next = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;
    if (wd_expired) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_next   = INHIBIT;
            inh_cnt_next = '0;
            clk_drv_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        INHIBIT: begin
          clk_drv_next = 1'b1;
          if (inh_cnt == INHIBIT_LAST) begin
            state_next    = START;
            data_drv_next = 1'b1;
          end else begin
            inh_cnt_next = inh_cnt + IW'(1);
          end
        end
        START: begin
          // Release the clock, keep data low as the start bit.
          state_next    = SEND;
          bit_cnt_next  = 4'd0;
          data_drv_next = 1'b1;
        end
        SEND: begin
          if (clk_fall) begin
            bit_cnt_next = bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              data_drv_next = ~frame_byte[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              data_drv_next = ~frame_parity;
            end else begin
              data_drv_next = 1'b0;
              state_next    = ACK;
            end
          end else begin
            data_drv_next = key_data_drv;
          end
        end
        ACK: begin
          if (clk_fall) begin
            state_next = IDLE;
            if (!data_sync) begin
              done_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end else begin
            state_next = ACK;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
    // Ready comes back the cycle after a done/err pulse.
    ready_next = (state_next == IDLE) && !done_next && !err_next;
  end

  // State, counter and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      inh_cnt      <= '0;
      bit_cnt      <= 4'd0;
      key_clk_drv  <= 1'b0;
      key_data_drv <= 1'b0;
      tx_ready     <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      state        <= state_next;
      inh_cnt      <= inh_cnt_next;
      bit_cnt      <= bit_cnt_next;
      key_clk_drv  <= clk_drv_next;
      key_data_drv <= data_drv_next;
      tx_ready     <= ready_next;
      tx_done      <= done_next;
      tx_err       <= err_next;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard queue holds the expected outcome of every issued command and
// a monitor compares whenever tx_done/tx_err fires.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 500;

  typedef struct {
    logic [7:0] data;
    bit         framed;
    bit         done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_clk, key_data;
  logic       key_clk_drv, key_data_drv;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err;

  logic dev_clk = 1'b1;
  logic dev_data_low = 1'b0;
  bit   dev_ack = 1'b1;
  bit   dev_silent = 1'b0;
  int   abort_at = 0;
  bit   abort_hit = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  exp_t        exp_q[$];
  logic [10:0] got_q[$];

  // Open-collector bus with pull-ups
  assign key_clk  = ~key_clk_drv & dev_clk;
  assign key_data = ~key_data_drv & ~dev_data_low;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_clk      (key_clk),
    .key_data     (key_data),
    .key_clk_drv  (key_clk_drv),
    .key_data_drv (key_data_drv),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .tx_err       (tx_err)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic void fail_now(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endfunction

  // Reference frame as seen on the wire: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = 11'd0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Device model: answers a request-to-send with 11 clock pulses, reading on rising edges
  initial begin : device
    logic [10:0] cap;
    bit seen_inhibit;
    seen_inhibit = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen_inhibit = 1'b0;
      end else if (key_clk_drv) begin
        seen_inhibit = 1'b1;
      end else if (seen_inhibit && key_data_drv) begin
        seen_inhibit = 1'b0;
        if (!dev_silent) begin
          cap = 11'd0;
          cap[0] = key_data;
          repeat (10) @(negedge clk);
          for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data_low = dev_ack;
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) cap[k] = key_data;
            if (k == 10) got_q.push_back(cap);
            if (k == 11) dev_data_low = 1'b0;
            if (k == abort_at) begin
              abort_hit = 1'b1;
              break;
            end
            repeat (5) @(negedge clk);
          end
        end
      end
    end
  end

  // Scoreboard monitor: every done/err pulse consumes one expected outcome
  initial begin : monitor
    exp_t e;
    logic [10:0] g;
    bit ready_due;
    ready_due = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_due) check("ready_after_pulse", 32'(tx_ready), 32'd1);
      ready_due = 1'b0;
      if (tx_done || tx_err) begin
        ready_due = 1'b1;
        check("done_err_exclusive", 32'(tx_done & tx_err), 32'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pulse", $sformatf("done=%0b err=%0b, required no pulse", tx_done, tx_err));
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", 32'(tx_done), 32'(e.done));
          check("outcome_err", 32'(tx_err), 32'(!e.done));
          if (tx_err) check("lines_released_on_err", 32'({key_clk_drv, key_data_drv}), 32'd0);
          if (e.framed) begin
            if (got_q.size() == 0) begin
              fail_now("frame_bits", "device captured no frame, required one");
            end else begin
              g = got_q.pop_front();
              check("frame_bits", 32'(g), 32'(frame_bits(e.data)));
            end
          end
        end
      end
    end
  end

  // Bus monitor: the clock is held low for the inhibit time plus the START cycle
  initial begin : line_mon
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else if (key_clk_drv) begin
        run++;
        if (key_data_drv) check("inhibit_len_at_start", 32'(run), 32'(INH + 1));
      end else if (run != 0) begin
        check("clk_drv_run", 32'(run), 32'(INH + 1));
        run = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] b, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) fail_now("accept_wait", "tx_ready never rose, required 1");
    @(negedge clk);
    check("ready_low_in_frame", 32'(tx_ready), 32'd0);
    if (hold) begin
      repeat (150) begin
        tx_data = 8'($urandom);
        @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_wait", "expected pulse never seen");
    repeat (30) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit ack, input bit hold);
    exp_t e;
    e.data   = b;
    e.framed = 1'b1;
    e.done   = ack;
    dev_ack  = ack;
    exp_q.push_back(e);
    issue(b, hold);
    drain();
  endtask

  initial begin : stimulus
    logic [7:0] b;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_err", 32'(tx_err), 32'd0);
    check("rst_clk_drv", 32'(key_clk_drv), 32'd0);
    check("rst_data_drv", 32'(key_data_drv), 32'd0);
    rst = 1'b0;
    check("ready_before_first_edge", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(tx_ready), 32'd1);

    send(ps2_pkg::CMD_SET_LED, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    send(8'($urandom), 1'b0, 1'b0);

    // tx_valid held with changing data: one frame with the latched byte
    send(8'($urandom), 1'b1, 1'b1);
    check("single_frame_clk_idle", 32'(key_clk_drv), 32'd0);
    check("single_frame_ready", 32'(tx_ready), 32'd1);

    // Reset after data bit 4 (bit 3 forced 0 so data is being driven)
    b = 8'($urandom) & 8'hF7;
    dev_ack  = 1'b1;
    abort_at = 4;
    issue(b, 1'b0);
    n = 0;
    while (!abort_hit && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!abort_hit) fail_now("abort_wait", "device never reached bit 4");
    check("data_drv_before_rst", 32'(key_data_drv), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_clk_drv", 32'(key_clk_drv), 32'd0);
    check("rst_mid_data_drv", 32'(key_data_drv), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    abort_at = 0;
    abort_hit = 1'b0;
    repeat (40) @(negedge clk);
    got_q.delete();
    send(ps2_pkg::CMD_RESET, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
    end

`ifdef PS2_TX_TIMEOUT_EN
    begin : timeout_case
      exp_t e;
      int c;
      dev_silent = 1'b1;
      e.data   = 8'h5A;
      e.framed = 1'b0;
      e.done   = 1'b0;
      exp_q.push_back(e);
      issue(8'h5A, 1'b0);
      n = 0;
      while (!key_data_drv && n < 1000) begin
        @(posedge clk);
        #1;
        n++;
      end
      c = 0;
      while (!tx_err && c < 2000) begin
        @(posedge clk);
        #1;
        c++;
      end
      check("timeout_cycles", 32'(c), 32'(TMO));
      drain();
      dev_silent = 1'b0;
    end
`endif

    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("got_queue_empty", 32'(got_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : global_limit
    #5000000;
    $display("FAIL global_limit: simulation did not finish, required finish");
    $fatal(1, "simulation time limit");
  end

endmodule
